pipeline_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline. Drives stall/flush for the IF/ID and ID/EX

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_load_use_cmp.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/hazard_load_use_cmp.sv
// Load-use detector: flags when the ID instruction reads the register a load in EX is about to write.
module hazard_load_use_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect sequencing for the 5-stage pipeline.
// Optional HAZ_PERF_CNT_EN adds stall-cycle and flush-event performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RST_HOLD    = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_branch_taken_i,
  input  logic       mem_busy_i,
  output logic       pc_write_o,
  output logic       if_id_stall_o,
  output logic       if_id_flush_o,
  output logic       id_ex_stall_o,
  output logic       id_ex_flush_o,
  output logic       back_stall_o,
  output logic       pc_redirect_o,
  output logic       mem_timeout_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_flush_events_o
`endif
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic               timeout_hit;
  logic               load_use;

  hazard_load_use_cmp u_load_use_cmp (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_use_rs1_i  (id_use_rs1_i),
    .id_use_rs2_i  (id_use_rs2_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .load_use_o    (load_use)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= INIT;
      hold_q    <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    wait_d        = wait_q;
    timeout_hit   = 1'b0;
    pc_write_o    = 1'b0;
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_stall_o = 1'b0;
    id_ex_flush_o = 1'b0;
    back_stall_o  = 1'b0;
    pc_redirect_o = 1'b0;

    case (state_q)
      INIT: begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        hold_d        = hold_q + 1'b1;
        if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = RUN;
          hold_d  = '0;
        end
      end
      RUN, MWAIT: begin
        if (mem_busy_i) begin
          // Whole pipeline freezes; flushes are suppressed so nothing is lost while waiting.
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          back_stall_o  = 1'b1;
          state_d       = MWAIT;
          if (state_q == RUN) begin
            wait_d = CNT_W'(1);
          end else if (wait_q != '1) begin
            wait_d = wait_q + 1'b1;
          end
          timeout_hit = (wait_d >= CNT_W'(MEM_TIMEOUT));
        end else begin
          state_d = RUN;
          wait_d  = '0;
          if (ex_branch_taken_i) begin
            pc_redirect_o = 1'b1;
            pc_write_o    = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (load_use) begin
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else begin
            pc_write_o = 1'b1;
          end
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    timeout_d = timeout_q | timeout_hit;
  end

  assign mem_timeout_o = timeout_q | timeout_hit;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!pc_write_o && (state_q != INIT)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (pc_redirect_o) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_flush_events_o = perf_flush_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver queues expected output vectors, monitor checks them.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       use1 = 1'b0, use2 = 1'b0, mem_read = 1'b0, br = 1'b0, busy = 1'b0;
  logic       pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       back_stall, pc_redirect, mem_timeout;
  logic [7:0] act;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  // {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, back_stall, pc_redirect, mem_timeout}
  localparam logic [7:0] INITV = 8'b0010_1000;
  localparam logic [7:0] NORM  = 8'b1000_0000;
  localparam logic [7:0] LU    = 8'b0100_1000;
  localparam logic [7:0] BR    = 8'b1010_1010;
  localparam logic [7:0] FRZ   = 8'b0101_0100;
  localparam logic [7:0] TO    = 8'b0000_0001;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .RST_HOLD    (4),
    .MEM_TIMEOUT (10),
    .CNT_W       (8)
  ) dut (
    .clk_i             (clk),
    .reset_i           (rst),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_use_rs1_i      (use1),
    .id_use_rs2_i      (use2),
    .ex_mem_read_i     (mem_read),
    .ex_rd_i           (ex_rd),
    .ex_branch_taken_i (br),
    .mem_busy_i        (busy),
    .pc_write_o        (pc_write),
    .if_id_stall_o     (if_id_stall),
    .if_id_flush_o     (if_id_flush),
    .id_ex_stall_o     (id_ex_stall),
    .id_ex_flush_o     (id_ex_flush),
    .back_stall_o      (back_stall),
    .pc_redirect_o     (pc_redirect),
    .mem_timeout_o     (mem_timeout)
  );

  assign act = {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                back_stall, pc_redirect, mem_timeout};

  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                      input logic b, input logic mb, input logic [7:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; use1 = u1; use2 = u2;
    mem_read = mr; ex_rd = rd; br = b; busy = mb;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic r, input logic [7:0] e, input string nm);
    step(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e, nm);
  endtask

  task automatic busy_cyc(input logic b, input logic [7:0] e, input string nm);
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, b, 1'b1, e, nm);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle against the queued expectation.
  initial begin
    logic [7:0] e;
    string      nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("[TB] FAIL %s: got %b expected %b", nm, act, e);
        end else begin
          $display("[TB] ok   %s: %b", nm, act);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    idle(1'b1, INITV, "reset_asserted");
    idle(1'b0, INITV, "init_1");
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, INITV, "init_2_inputs_ignored");
    busy_cyc(1'b0, INITV, "init_3_busy_ignored");
    idle(1'b0, INITV, "init_4");
    idle(1'b0, NORM, "run_first");

    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, LU, "lu_rs1");
    idle(1'b0, NORM, "after_lu_bubble");
    step(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, LU, "lu_rs2");
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, NORM, "lu_rd_zero");
    step(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, NORM, "lu_rs1_unused");
    step(1'b0, 5'd6, 5'd4, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, NORM, "lu_no_match");
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, NORM, "match_not_load");
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, BR, "lu_plus_branch");
    idle(1'b0, NORM, "after_branch");

    for (int i = 1; i <= 3; i++) busy_cyc(1'b1, FRZ, $sformatf("busy_branch_%0d", i));
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, BR, "busy_drop_redirect");
    idle(1'b0, NORM, "after_busy");
    busy_cyc(1'b0, FRZ, "busy_short");
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, LU, "busy_drop_loaduse");

    for (int i = 1; i <= 12; i++)
      busy_cyc(1'b0, (i >= 10) ? (FRZ | TO) : FRZ, $sformatf("timeout_busy_%0d", i));
    idle(1'b0, NORM | TO, "timeout_sticky_run");
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, LU | TO, "timeout_sticky_lu");
    busy_cyc(1'b0, FRZ | TO, "timeout_sticky_busy");
    busy_cyc(1'b0, INITV, "reset_mid_mwait");
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) idle(1'b0, INITV, $sformatf("reinit_%0d", i));
    idle(1'b0, NORM, "rerun_timeout_cleared");
    busy_cyc(1'b0, FRZ, "busy_after_reset");
    idle(1'b0, NORM, "final_run");

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
